// File: rtl/sum_accum.sv
// Signed group summer: accumulates 1..MAX_LEN samples per group and emits one sum per group
// over valid/ready handshakes. Define SUM_ACCUM_SAT_EN to saturate on overflow instead of wrapping.
module sum_accum #(
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 40,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LEN_W-1:0]         len,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     ovf
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
`ifdef SUM_ACCUM_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_NEG = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic signed [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0]        r_count;
  logic [LEN_W-1:0]        r_cur_len;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_data;
  logic                    r_done;
  logic                    r_ovf;

  logic [LEN_W-1:0]        w_len_clamped;
  logic [LEN_W-1:0]        w_eff_len;
  logic [LEN_W:0]          w_count_inc;
  logic                    w_last;
  logic                    w_accept;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_raw;
  logic                    w_add_ovf;
  logic signed [ACC_W-1:0] w_sum;

  // Group length as it would be latched now; cur_len only applies once a group has started.
  assign w_len_clamped = (len == '0)     ? LEN_ONE :
                         (len > LEN_MAX) ? LEN_MAX : len;
  assign w_eff_len     = (r_count == '0) ? w_len_clamped : r_cur_len;
  assign w_count_inc   = (LEN_W+1)'(r_count) + (LEN_W+1)'(1);
  assign w_last        = (w_count_inc == {1'b0, w_eff_len});

  // Only the completing sample is held off while a finished sum is stalled downstream.
  assign in_ready = !clear && !(r_out_valid && !out_ready && w_last);
  assign w_accept = in_valid && in_ready;

  assign w_ext     = ACC_W'(in_data);
  assign w_base    = (r_count == '0) ? '0 : r_acc;
  assign w_raw     = w_base + w_ext;
  assign w_add_ovf = (w_base[ACC_W-1] == w_ext[ACC_W-1]) && (w_raw[ACC_W-1] != w_base[ACC_W-1]);

  always_comb begin
    // NOTE: default assigned first so every path drives w_sum and no latch is inferred.
    w_sum = w_raw;
`ifdef SUM_ACCUM_SAT_EN
    if (w_add_ovf) w_sum = w_base[ACC_W-1] ? ACC_NEG : ACC_POS;
`endif
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_count     <= '0;
      r_cur_len   <= LEN_ONE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= w_accept && w_last;

      if (w_accept && w_last) begin
        r_out_data  <= w_sum;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && w_add_ovf) r_ovf <= 1'b1;

      if (clear) begin
        r_count <= '0;
        r_acc   <= '0;
      end else if (w_accept) begin
        if (r_count == '0) r_cur_len <= w_len_clamped;
        if (w_last) begin
          r_count <= '0;
        end else begin
          r_count <= w_count_inc[LEN_W-1:0];
          r_acc   <= w_sum;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule
